// File: rtl/tia_audio_pkg.sv
// Shared types, register addresses and write decode/apply helpers for the TIA audio sequencer.
package tia_audio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CH0    = 2'd1,
    CH1    = 2'd2,
    COMMIT = 2'd3
  } aud_state_t;

  localparam logic [5:0] ADDR_AUDC0 = 6'h15;
  localparam logic [5:0] ADDR_AUDC1 = 6'h16;
  localparam logic [5:0] ADDR_AUDF0 = 6'h17;
  localparam logic [5:0] ADDR_AUDF1 = 6'h18;
  localparam logic [5:0] ADDR_AUDV0 = 6'h19;
  localparam logic [5:0] ADDR_AUDV1 = 6'h1A;

  // reg_sel is the address offset from AUDC0
  localparam logic [2:0] SEL_AUDC0 = 3'd0;
  localparam logic [2:0] SEL_AUDC1 = 3'd1;
  localparam logic [2:0] SEL_AUDF0 = 3'd2;
  localparam logic [2:0] SEL_AUDF1 = 3'd3;
  localparam logic [2:0] SEL_AUDV0 = 3'd4;
  localparam logic [2:0] SEL_AUDV1 = 3'd5;

  typedef struct packed {
    logic [2:0] reg_sel;
    logic [4:0] data;
  } aud_wr_t;

  typedef struct packed {
    logic [3:0] audc0;
    logic [3:0] audc1;
    logic [4:0] audf0;
    logic [4:0] audf1;
    logic [3:0] audv0;
    logic [3:0] audv1;
  } aud_regs_t;

  function automatic logic aud_addr_valid(input logic [5:0] addr);
    return (addr >= ADDR_AUDC0) && (addr <= ADDR_AUDV1);
  endfunction

  function automatic aud_wr_t aud_decode(input logic [5:0] addr, input logic [5:0] data);
    aud_wr_t w;
    w.reg_sel = 3'(addr - ADDR_AUDC0);
    w.data    = 5'(data & (((w.reg_sel == SEL_AUDF0) || (w.reg_sel == SEL_AUDF1)) ? 6'h1F : 6'h0F));
    return w;
  endfunction

  function automatic aud_regs_t aud_apply(input aud_regs_t r, input aud_wr_t w);
    aud_regs_t n;
    n = r;
    case (w.reg_sel)
      SEL_AUDC0: n.audc0 = w.data[3:0];
      SEL_AUDC1: n.audc1 = w.data[3:0];
      SEL_AUDF0: n.audf0 = w.data;
      SEL_AUDF1: n.audf1 = w.data;
      SEL_AUDV0: n.audv0 = w.data[3:0];
      SEL_AUDV1: n.audv1 = w.data[3:0];
      default: ;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tia_aud_wr_fifo.sv
// Synchronous FIFO of decoded register writes; used when TIA_AUDIO_WRFIFO_EN is defined.
module tia_aud_wr_fifo
  import tia_audio_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  aud_wr_t push_data,
  input  logic    pop,
  output aud_wr_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  aud_wr_t     mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  // extra pointer bit distinguishes full from empty when the indices match
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty    = (wptr == rptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tia_audio_sequencer.sv
// TIA audio controller: sample tick, shared channel divider, register commit.
// TIA_AUDIO_WRFIFO_EN: queue CPU writes and commit them after each sample step.
module tia_audio_sequencer
  import tia_audio_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 114,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [5:0] wr_data,
  output logic       wr_ready,
  output logic       tick_30,
  output logic [1:0] ch_step,
  output logic [3:0] audc0,
  output logic [3:0] audc1,
  output logic [4:0] audf0,
  output logic [4:0] audf1,
  output logic [3:0] audv0,
  output logic [3:0] audv1,
  output logic       overrun
);

  localparam int unsigned        DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]      DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  aud_state_t    state;
  aud_state_t    state_nx;
  aud_regs_t     regs;
  logic [4:0]    fcnt0;
  logic [4:0]    fcnt1;
  logic [4:0]    dec_cur;
  logic [4:0]    dec_nxt;
  logic          dec_zero;
  logic          wr_hit;
  aud_wr_t       wr_item;
  logic          commit_vld;
  aud_wr_t       commit_item;

  assign tick_30 = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset || tick_30) div_cnt <= '0;
    else                  div_cnt <= div_cnt + 1'b1;
  end

  assign wr_hit  = wr_en && wr_ready && aud_addr_valid(wr_addr);
  assign wr_item = aud_decode(wr_addr, wr_data);

`ifdef TIA_AUDIO_WRFIFO_EN
  logic fifo_full;
  logic fifo_empty;

  tia_aud_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_hit),
    .push_data (wr_item),
    .pop       (commit_vld),
    .pop_data  (commit_item),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_ready   = !fifo_full;
  assign commit_vld = (state == COMMIT) && !fifo_empty;
`else
  assign wr_ready    = 1'b1;
  assign commit_vld  = wr_hit;
  assign commit_item = wr_item;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (tick_30) state_nx = CH0;
      CH0:  state_nx = CH1;
`ifdef TIA_AUDIO_WRFIFO_EN
      CH1:    state_nx = COMMIT;
      COMMIT: if (fifo_empty) state_nx = IDLE;
`else
      CH1:  state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // one decrementer serves both channels; CH1 selects channel 1, otherwise channel 0
  always_comb begin
    dec_cur  = (state == CH1) ? fcnt1 : fcnt0;
    dec_zero = (dec_cur == 5'd0);
    dec_nxt  = dec_zero ? ((state == CH1) ? regs.audf1 : regs.audf0) : (dec_cur - 5'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      fcnt0   <= '0;
      fcnt1   <= '0;
      ch_step <= '0;
      overrun <= 1'b0;
      regs    <= '0;
    end else begin
      state <= state_nx;
      if (state == CH0) fcnt0 <= dec_nxt;
      if (state == CH1) fcnt1 <= dec_nxt;
      ch_step <= {(state == CH1) && dec_zero, (state == CH0) && dec_zero};
      if (tick_30 && (state != IDLE)) overrun <= 1'b1;
      if (commit_vld) regs <= aud_apply(regs, commit_item);
    end
  end

  assign audc0 = regs.audc0;
  assign audc1 = regs.audc1;
  assign audf0 = regs.audf0;
  assign audf1 = regs.audf1;
  assign audv0 = regs.audv0;
  assign audv1 = regs.audv1;

endmodule

// File: tb/tb_tia_audio_sequencer.sv
// Self-checking bench for tia_audio_sequencer: directed tables plus randomized writes vs. a timeline model.
module tb_tia_audio_sequencer;

  localparam int DIV    = 114;
  localparam int DEPTH  = 4;
  localparam int OV_DIV = 2;
`ifdef TIA_AUDIO_WRFIFO_EN
  localparam bit FIFO_ON = 1'b1;
`else
  localparam bit FIFO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [5:0] wr_data = '0;
  logic       wr_ready, tick_30, overrun;
  logic [1:0] ch_step;
  logic [3:0] audc0, audc1, audv0, audv1;
  logic [4:0] audf0, audf1;

  logic       o_reset = 1'b1;
  logic       o_wr_en = 1'b0;
  logic [5:0] o_wr_addr = '0;
  logic [5:0] o_wr_data = '0;
  logic       o_wr_ready, o_tick_30, o_overrun;
  logic [1:0] o_ch_step;
  logic [3:0] o_audc0, o_audc1, o_audv0, o_audv1;
  logic [4:0] o_audf0, o_audf1;

  always #5 clk = ~clk;

  tia_audio_sequencer #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .tick_30(tick_30), .ch_step(ch_step),
    .audc0(audc0), .audc1(audc1), .audf0(audf0), .audf1(audf1),
    .audv0(audv0), .audv1(audv1), .overrun(overrun)
  );

  tia_audio_sequencer #(.CLK_DIV(OV_DIV), .FIFO_DEPTH(DEPTH)) dut_ov (
    .clk(clk), .reset(o_reset), .wr_en(o_wr_en), .wr_addr(o_wr_addr), .wr_data(o_wr_data),
    .wr_ready(o_wr_ready), .tick_30(o_tick_30), .ch_step(o_ch_step),
    .audc0(o_audc0), .audc1(o_audc1), .audf0(o_audf0), .audf1(o_audf1),
    .audv0(o_audv0), .audv1(o_audv1), .overrun(o_overrun)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference timeline: m_since counts cycles since an accepted tick (0 = idle).
  typedef struct { int idx; int val; } qent_t;
  int       m_cnt, m_since;
  int       m_f [2];
  int       m_reg [6];
  bit [1:0] m_step;
  bit       m_ovr;
  qent_t    m_q [$];

  typedef struct { logic [5:0] addr; logic [5:0] data; bit exp_ready; } wr_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {1'b0, wr_ready, tick_30, ch_step, audc0, audc1, audf0, audf1, audv0, audv1, overrun};
  endfunction

  function automatic logic [31:0] model_vec();
    logic rdy;
    rdy = FIFO_ON ? (m_q.size() < DEPTH) : 1'b1;
    return {1'b0, rdy, (m_cnt == DIV - 1), m_step, 4'(m_reg[0]), 4'(m_reg[1]),
            5'(m_reg[2]), 5'(m_reg[3]), 4'(m_reg[4]), 4'(m_reg[5]), m_ovr};
  endfunction

  function automatic logic [25:0] regs_vec();
    return {audc0, audc1, audf0, audf1, audv0, audv1};
  endfunction

  task automatic model_edge(input logic en, input logic [5:0] a, input logic [5:0] d, input logic rst);
    bit       tick, rdy;
    bit [1:0] nstep;
    int       nsince, idx, val;
    qent_t    e;
    if (rst) begin
      m_cnt = 0; m_since = 0; m_f = '{0, 0}; m_reg = '{default: 0};
      m_step = '0; m_ovr = 1'b0; m_q.delete();
      return;
    end
    tick  = (m_cnt == DIV - 1);
    rdy   = FIFO_ON ? (m_q.size() < DEPTH) : 1'b1;
    nstep = '0;
    nsince = 0;
    if (m_since == 1 || m_since == 2) begin
      idx = m_since - 1;
      if (m_f[idx] == 0) begin
        m_f[idx] = m_reg[2 + idx];
        nstep[idx] = 1'b1;
      end else begin
        m_f[idx]--;
      end
    end
    if (m_since == 0)      nsince = tick ? 1 : 0;
    else if (m_since == 1) nsince = 2;
    else if (m_since == 2) nsince = FIFO_ON ? 3 : 0;
    else if (m_q.size() != 0) begin
      e = m_q.pop_front();
      m_reg[e.idx] = e.val;
      nsince = 3;
    end
    if (tick && m_since != 0) m_ovr = 1'b1;
    if (en && rdy && a >= 6'h15 && a <= 6'h1A) begin
      idx = int'(a) - 'h15;
      val = (idx == 2 || idx == 3) ? (int'(d) % 32) : (int'(d) % 16);
      if (FIFO_ON) m_q.push_back('{idx, val});
      else         m_reg[idx] = val;
    end
    m_cnt  = (m_cnt + 1) % DIV;
    m_step = nstep;
    m_since = nsince;
  endtask

  task automatic cyc(input logic en, input logic [5:0] a, input logic [5:0] d, input logic rst);
    wr_en = en; wr_addr = a; wr_data = d; reset = rst;
    @(posedge clk);
    model_edge(en, a, d, rst);
    @(negedge clk);
    chk("cycle_model", dut_vec(), model_vec());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 6'h0, 6'h0, 1'b0);
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * DIV && !seen; i++) begin
      cyc(1'b0, 6'h0, 6'h0, 1'b0);
      if (tick_30) seen = 1'b1;
    end
    chk("tick_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    wr_vec_t burst [5];
    wr_vec_t batch [3];
    int      ticks, last, n0, n1;
    logic    ren, rrst;
    logic [5:0] raddr, rdata;
    int      r;

    burst[0] = '{6'h15, 6'h31, 1'b1};
    burst[1] = '{6'h16, 6'h22, 1'b1};
    burst[2] = '{6'h19, 6'h13, 1'b1};
    burst[3] = '{6'h1A, 6'h34, 1'b1};
    burst[4] = '{6'h18, 6'h29, !FIFO_ON};
    batch[0] = '{6'h19, 6'h3F, 1'b1};
    batch[1] = '{6'h19, 6'h05, 1'b1};
    batch[2] = '{6'h20, 6'h1F, 1'b1};

    @(negedge clk);
    cyc(1'b0, 6'h0, 6'h0, 1'b1);
    cyc(1'b0, 6'h0, 6'h0, 1'b1);
    chk("reset_state", dut_vec(), 32'h4000_0000);

    // idle: tick period and quiet outputs
    ticks = 0; last = -1;
    for (int i = 0; i < 3 * DIV; i++) begin
      cyc(1'b0, 6'h0, 6'h0, 1'b0);
      if (tick_30) begin
        if (last >= 0) chk("tick_period", 32'(i - last), 32'(DIV));
        last = i;
        ticks++;
      end
    end
    chk("tick_count", 32'(ticks), 32'd3);
    chk("overrun_idle", 32'(overrun), 32'd0);

    // AUDF0 write: deferred to commit when buffered, immediate otherwise
    cyc(1'b1, 6'h17, 6'h03, 1'b0);
    chk("audf0_after_write", 32'(audf0), FIFO_ON ? 32'd0 : 32'd3);
    wait_tick();
    run(8);
    chk("audf0_committed", 32'(audf0), 32'd3);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 12 * DIV; i++) begin
      cyc(1'b0, 6'h0, 6'h0, 1'b0);
      n0 += int'(ch_step[0]);
      n1 += int'(ch_step[1]);
    end
    chk("ch0_steps_12ticks", 32'(n0), 32'd3);
    chk("ch1_steps_12ticks", 32'(n1), 32'd12);

    // back-to-back burst against FIFO depth
    for (int i = 0; i < 5; i++) begin
      chk("burst_ready", 32'(wr_ready), 32'(burst[i].exp_ready));
      cyc(1'b1, burst[i].addr, burst[i].data, 1'b0);
    end
    wait_tick();
    run(7);
    chk("burst_commit", 32'(regs_vec()),
        32'({4'd1, 4'd2, 5'd3, (FIFO_ON ? 5'd0 : 5'd9), 4'd3, 4'd4}));

    // same-register batch, last wins; unknown address dropped
    for (int i = 0; i < 3; i++) cyc(1'b1, batch[i].addr, batch[i].data, 1'b0);
    wait_tick();
    run(7);
    chk("batch_last_wins", 32'(audv0), 32'd5);
    chk("batch_regs", 32'(regs_vec()),
        32'({4'd1, 4'd2, 5'd3, (FIFO_ON ? 5'd0 : 5'd9), 4'd5, 4'd4}));

    // reset in the middle of a commit drain
    cyc(1'b1, 6'h15, 6'h07, 1'b0);
    cyc(1'b1, 6'h16, 6'h07, 1'b0);
    cyc(1'b1, 6'h19, 6'h07, 1'b0);
    cyc(1'b1, 6'h1A, 6'h07, 1'b0);
    wait_tick();
    run(4);
    cyc(1'b0, 6'h0, 6'h0, 1'b1);
    chk("reset_mid_commit", dut_vec(), 32'h4000_0000);
    wait_tick();
    run(10);
    chk("queued_lost", 32'(regs_vec()), 32'd0);

    // randomized writes, occasional reset
    for (int i = 0; i < 40 * DIV; i++) begin
      ren  = ($urandom % 24) == 0;
      rrst = ($urandom % 3000) == 0;
      r = int'($urandom % 8);
      if (r < 6)       raddr = 6'(8'h15 + r);
      else if (r == 6) raddr = 6'h20;
      else             raddr = 6'($urandom % 64);
      if (raddr == 6'h17 || raddr == 6'h18) rdata = 6'($urandom_range(0, 4) + (($urandom % 2) * 32));
      else                                  rdata = 6'($urandom % 64);
      cyc(ren, raddr, rdata, rrst);
    end
    wr_en = 1'b0;

    // short divider: tick lands while the FSM is in CH1
    o_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ov_reset", 32'(o_overrun), 32'd0);
    o_reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("ov_before", 32'(o_overrun), 32'd0);
    @(negedge clk);
    chk("ov_set", 32'(o_overrun), 32'd1);
    repeat (10) @(negedge clk);
    chk("ov_sticky", 32'(o_overrun), 32'd1);
    o_reset = 1'b1;
    @(negedge clk);
    chk("ov_cleared", 32'(o_overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
